mcpu_ctrl: RTL and testbench

Multi-cycle main controller for the MCPU datapath. It sequences each instruction through IF/ID/EX/MEM/WB phases. It decodes the latched instruction word into the 5-bit ALU opcode and datapath selects, and drives the ALU's `work` (EX_signal) strobe. It sits directly upstream of the ALU and consumes the ALU's Zero/Gez/Overflow flags for branch resolution and overflow trapping.

---
 rtl/mcpu_ctrl_pkg.sv | 119 +++++++++++
 rtl/mcpu_ctrl_if.sv | 41 ++++
 rtl/mcpu_decode.sv | 129 ++++++++++++
 rtl/mcpu_ctrl.sv | 133 +++++++++++++
 tb/tb_mcpu_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the MCPU controller: ALU opcodes, instruction fields,
// datapath select codes, FSM states and the decode record.
package mcpu_ctrl_pkg;

  // ALU opcodes
  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_ADDU = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SUBU = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_NOR  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;
  localparam logic [4:0] ALU_SLL  = 5'd11;
  localparam logic [4:0] ALU_SRL  = 5'd12;
  localparam logic [4:0] ALU_SRA  = 5'd13;
  localparam logic [4:0] ALU_LUI  = 5'd14;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // REGIMM rt selector for bgez
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // Datapath select codes
  localparam logic [1:0] PC_SRC_PC4  = 2'd0;
  localparam logic [1:0] PC_SRC_BR   = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP = 2'd2;
  localparam logic [1:0] PC_SRC_REG  = 2'd3;

  localparam logic [1:0] RD_SEL_RT = 2'd0;
  localparam logic [1:0] RD_SEL_RD = 2'd1;
  localparam logic [1:0] RD_SEL_RA = 2'd2;

  localparam logic [1:0] WD_SEL_ALU = 2'd0;
  localparam logic [1:0] WD_SEL_MEM = 2'd1;
  localparam logic [1:0] WD_SEL_PC4 = 2'd2;

  // One-hot controller states
  typedef enum logic [5:0] {
    StRst = 6'b000001,
    StIf  = 6'b000010,
    StId  = 6'b000100,
    StEx  = 6'b001000,
    StMem = 6'b010000,
    StWb  = 6'b100000
  } state_e;

  // Instruction class, picks the exit path out of EX
  typedef enum logic [3:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBeq,
    ClsBne,
    ClsBgez,
    ClsJ,
    ClsJal,
    ClsJr
  } cls_e;

  typedef struct packed {
    logic [4:0] alu_op;
    logic       alusrc_b;
    logic       ext_op;
    logic [1:0] rd_sel;
    logic [1:0] wd_sel;
    cls_e       cls;
  } dec_t;

  localparam dec_t DecReset = '{
    alu_op:   ALU_NOP,
    alusrc_b: 1'b0,
    ext_op:   1'b0,
    rd_sel:   RD_SEL_RT,
    wd_sel:   WD_SEL_ALU,
    cls:      ClsAlu
  };

  // Only signed add/sub can raise an overflow trap
  function automatic logic is_ovf_op(logic [4:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/mcpu_ctrl_if.sv
// Controller <-> datapath bundle: IR and ALU flags in, strobes and selects out.
interface mcpu_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        gez;
  logic        overflow;

  logic        if_signal;
  logic        id_signal;
  logic        ex_signal;
  logic        mem_signal;
  logic        wb_signal;
  logic [4:0]  alu_op;
  logic        alusrc_b;
  logic        ext_op;
  logic        reg_write;
  logic [1:0]  rd_sel;
  logic [1:0]  wd_sel;
  logic        mem_read;
  logic        mem_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ov_trap;
  logic        illegal;

  // Controller side
  modport master (
    input  instr, zero, gez, overflow,
    output if_signal, id_signal, ex_signal, mem_signal, wb_signal,
    output alu_op, alusrc_b, ext_op, reg_write, rd_sel, wd_sel,
    output mem_read, mem_write, pc_write, pc_src, ov_trap, illegal
  );

  // Datapath side
  modport slave (
    output instr, zero, gez, overflow,
    input  if_signal, id_signal, ex_signal, mem_signal, wb_signal,
    input  alu_op, alusrc_b, ext_op, reg_write, rd_sel, wd_sel,
    input  mem_read, mem_write, pc_write, pc_src, ov_trap, illegal
  );
endinterface

// File: rtl/mcpu_decode.sv
// Combinational instruction decoder: instruction word -> ALU op, selects, class.
module mcpu_decode
  import mcpu_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o,
  output logic        illegal_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign rt    = instr_i[20:16];

  // rs, immediate and shamt only matter to the datapath
  logic unused_fields;
  assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};

  // Decode table; defaults describe a sign-extended, rt-targeted ALU op
  always_comb begin
    dec_o = '{
      alu_op:   ALU_NOP,
      alusrc_b: 1'b0,
      ext_op:   1'b1,
      rd_sel:   RD_SEL_RT,
      wd_sel:   WD_SEL_ALU,
      cls:      ClsAlu
    };
    illegal_o = 1'b0;

    case (op)
      OP_RTYPE: begin
        dec_o.rd_sel = RD_SEL_RD;
        case (funct)
          FN_SLL:  dec_o.alu_op = ALU_SLL;
          FN_SRL:  dec_o.alu_op = ALU_SRL;
          FN_SRA:  dec_o.alu_op = ALU_SRA;
          FN_JR:   dec_o.cls    = ClsJr;
          FN_ADD:  dec_o.alu_op = ALU_ADD;
          FN_ADDU: dec_o.alu_op = ALU_ADDU;
          FN_SUB:  dec_o.alu_op = ALU_SUB;
          FN_SUBU: dec_o.alu_op = ALU_SUBU;
          FN_AND:  dec_o.alu_op = ALU_AND;
          FN_OR:   dec_o.alu_op = ALU_OR;
          FN_XOR:  dec_o.alu_op = ALU_XOR;
          FN_NOR:  dec_o.alu_op = ALU_NOR;
          FN_SLT:  dec_o.alu_op = ALU_SLT;
          FN_SLTU: dec_o.alu_op = ALU_SLTU;
          default: illegal_o    = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        // Gez is derived from operand A; subtract keeps the flags meaningful
        if (rt == RT_BGEZ) begin
          dec_o.cls    = ClsBgez;
          dec_o.alu_op = ALU_SUB;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_J:   dec_o.cls = ClsJ;
      OP_JAL: begin
        dec_o.cls    = ClsJal;
        dec_o.rd_sel = RD_SEL_RA;
        dec_o.wd_sel = WD_SEL_PC4;
      end
      OP_BEQ: begin
        dec_o.cls    = ClsBeq;
        dec_o.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        dec_o.cls    = ClsBne;
        dec_o.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        dec_o.alu_op   = ALU_ADD;
        dec_o.alusrc_b = 1'b1;
      end
      OP_ADDIU: begin
        dec_o.alu_op   = ALU_ADDU;
        dec_o.alusrc_b = 1'b1;
      end
      OP_SLTI: begin
        dec_o.alu_op   = ALU_SLT;
        dec_o.alusrc_b = 1'b1;
      end
      OP_SLTIU: begin
        dec_o.alu_op   = ALU_SLTU;
        dec_o.alusrc_b = 1'b1;
        dec_o.ext_op   = 1'b0;
      end
      OP_ANDI: begin
        dec_o.alu_op   = ALU_AND;
        dec_o.alusrc_b = 1'b1;
        dec_o.ext_op   = 1'b0;
      end
      OP_ORI: begin
        dec_o.alu_op   = ALU_OR;
        dec_o.alusrc_b = 1'b1;
        dec_o.ext_op   = 1'b0;
      end
      OP_XORI: begin
        dec_o.alu_op   = ALU_XOR;
        dec_o.alusrc_b = 1'b1;
        dec_o.ext_op   = 1'b0;
      end
      OP_LUI: begin
        dec_o.alu_op   = ALU_LUI;
        dec_o.alusrc_b = 1'b1;
      end
      OP_LW: begin
        dec_o.cls      = ClsLoad;
        dec_o.alu_op   = ALU_ADD;
        dec_o.alusrc_b = 1'b1;
        dec_o.wd_sel   = WD_SEL_MEM;
      end
      OP_SW: begin
        dec_o.cls      = ClsStore;
        dec_o.alu_op   = ALU_ADD;
        dec_o.alusrc_b = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MCPU main controller: IF/ID/EX/MEM/WB sequencing, decode
// latching, branch resolution and overflow/illegal trapping.
module mcpu_ctrl
  import mcpu_ctrl_pkg::*;
(
  input logic         clk,
  input logic         rstn,
  mcpu_ctrl_if.master ctrl_io
);

  state_e state_q, state_d;
  dec_t   dec, dec_q;
  logic   dec_illegal;

  mcpu_decode u_decode (
    .instr_i   (ctrl_io.instr),
    .dec_o     (dec),
    .illegal_o (dec_illegal)
  );

  // State register; reset parks the FSM in StRst with every output low
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the decode on the ID->EX edge; fields hold until the next ID
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dec_q <= DecReset;
    end else if (state_q == StId) begin
      dec_q <= dec;
    end
  end

  // Operand selects follow the live decode in ID, so they are stable from ID through EX
  assign ctrl_io.alu_op   = (state_q == StId) ? dec.alu_op   : dec_q.alu_op;
  assign ctrl_io.alusrc_b = (state_q == StId) ? dec.alusrc_b : dec_q.alusrc_b;
  assign ctrl_io.ext_op   = (state_q == StId) ? dec.ext_op   : dec_q.ext_op;
  assign ctrl_io.rd_sel   = dec_q.rd_sel;
  assign ctrl_io.wd_sel   = dec_q.wd_sel;

  // Next-state and per-state strobes; branch decisions use the EX-cycle flags
  always_comb begin
    state_d            = state_q;
    ctrl_io.if_signal  = 1'b0;
    ctrl_io.id_signal  = 1'b0;
    ctrl_io.ex_signal  = 1'b0;
    ctrl_io.mem_signal = 1'b0;
    ctrl_io.wb_signal  = 1'b0;
    ctrl_io.reg_write  = 1'b0;
    ctrl_io.mem_read   = 1'b0;
    ctrl_io.mem_write  = 1'b0;
    ctrl_io.pc_write   = 1'b0;
    ctrl_io.pc_src     = PC_SRC_PC4;
    ctrl_io.ov_trap    = 1'b0;
    ctrl_io.illegal    = 1'b0;

    unique case (state_q)
      StRst: state_d = StIf;
      StIf: begin
        ctrl_io.if_signal = 1'b1;
        ctrl_io.pc_write  = 1'b1;
        state_d           = StId;
      end
      StId: begin
        ctrl_io.id_signal = 1'b1;
        if (dec_illegal) begin
          ctrl_io.illegal = 1'b1;
          state_d         = StIf;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        ctrl_io.ex_signal = 1'b1;
        state_d           = StIf;
        case (dec_q.cls)
          ClsAlu: begin
            if (is_ovf_op(dec_q.alu_op) && ctrl_io.overflow) begin
              ctrl_io.ov_trap = 1'b1;
            end else begin
              state_d = StWb;
            end
          end
          ClsLoad, ClsStore: state_d = StMem;
          ClsBeq, ClsBne, ClsBgez: begin
            if ((dec_q.cls == ClsBeq  &&  ctrl_io.zero) ||
                (dec_q.cls == ClsBne  && !ctrl_io.zero) ||
                (dec_q.cls == ClsBgez &&  ctrl_io.gez)) begin
              ctrl_io.pc_write = 1'b1;
              ctrl_io.pc_src   = PC_SRC_BR;
            end
          end
          ClsJ: begin
            ctrl_io.pc_write = 1'b1;
            ctrl_io.pc_src   = PC_SRC_JUMP;
          end
          ClsJal: begin
            ctrl_io.pc_write = 1'b1;
            ctrl_io.pc_src   = PC_SRC_JUMP;
            state_d          = StWb;
          end
          ClsJr: begin
            ctrl_io.pc_write = 1'b1;
            ctrl_io.pc_src   = PC_SRC_REG;
          end
          default: state_d = StIf;
        endcase
      end
      StMem: begin
        ctrl_io.mem_signal = 1'b1;
        if (dec_q.cls == ClsLoad) begin
          ctrl_io.mem_read = 1'b1;
          state_d          = StWb;
        end else begin
          ctrl_io.mem_write = 1'b1;
          state_d           = StIf;
        end
      end
      StWb: begin
        ctrl_io.wb_signal = 1'b1;
        ctrl_io.reg_write = 1'b1;
        state_d           = StIf;
      end
      default: state_d = StRst;
    endcase
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for mcpu_ctrl: walks each instruction class cycle by cycle
// and compares strobes and selects against hand-computed vectors.
module tb_mcpu_ctrl;
  import mcpu_ctrl_pkg::*;

  // Strobe vector bits:
  // {if, id, ex, mem, wb, reg_write, mem_read, mem_write, pc_write, ov_trap, illegal}
  localparam logic [10:0] EnNone  = 11'b000_0000_0000;
  localparam logic [10:0] EnIf    = 11'b100_0000_0100;
  localparam logic [10:0] EnId    = 11'b010_0000_0000;
  localparam logic [10:0] EnIdIll = 11'b010_0000_0001;
  localparam logic [10:0] EnEx    = 11'b001_0000_0000;
  localparam logic [10:0] EnExPc  = 11'b001_0000_0100;
  localparam logic [10:0] EnExOv  = 11'b001_0000_0010;
  localparam logic [10:0] EnMemR  = 11'b000_1001_0000;
  localparam logic [10:0] EnMemW  = 11'b000_1000_1000;
  localparam logic [10:0] EnWb    = 11'b000_0110_0000;

  logic clk = 1'b0;
  logic rstn;
  int   n_total = 0;
  int   n_bad   = 0;

  mcpu_ctrl_if ctrl_if ();

  mcpu_ctrl u_dut (
    .clk     (clk),
    .rstn    (rstn),
    .ctrl_io (ctrl_if)
  );

  logic [10:0] en;
  assign en = {ctrl_if.if_signal, ctrl_if.id_signal, ctrl_if.ex_signal, ctrl_if.mem_signal,
               ctrl_if.wb_signal, ctrl_if.reg_write, ctrl_if.mem_read, ctrl_if.mem_write,
               ctrl_if.pc_write, ctrl_if.ov_trap, ctrl_if.illegal};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge
  task automatic step(input string tag, input logic [10:0] exp);
    @(posedge clk);
    #1;
    check_eq(tag, 32'(en), 32'(exp));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rstn              = 1'b1;
    ctrl_if.instr     = 32'h0;
    ctrl_if.zero      = 1'b0;
    ctrl_if.gez       = 1'b0;
    ctrl_if.overflow  = 1'b0;
    #1 rstn = 1'b0;
    #20;
    check_eq("rst_en", 32'(en), 32'(EnNone));
    check_eq("rst_alu_op", 32'(ctrl_if.alu_op), 32'(ALU_NOP));
    check_eq("rst_sel", 32'({ctrl_if.alusrc_b, ctrl_if.ext_op, ctrl_if.rd_sel,
                             ctrl_if.wd_sel, ctrl_if.pc_src}), 32'd0);

    // addu $3,$1,$2
    ctrl_if.instr = 32'h00221821;
    @(negedge clk);
    rstn = 1'b1;
    step("addu_if", EnIf);
    check_eq("addu_if_pcsrc", 32'(ctrl_if.pc_src), 32'd0);
    step("addu_id", EnId);
    check_eq("addu_id_aluop", 32'(ctrl_if.alu_op), 32'(ALU_ADDU));
    step("addu_ex", EnEx);
    check_eq("addu_ex_aluop", 32'(ctrl_if.alu_op), 32'(ALU_ADDU));
    step("addu_wb", EnWb);
    check_eq("addu_wb_rdsel", 32'(ctrl_if.rd_sel), 32'd1);
    check_eq("addu_wb_wdsel", 32'(ctrl_if.wd_sel), 32'd0);
    step("addu_next", EnIf);

    // lw $2,4($1)
    ctrl_if.instr = 32'h8C220004;
    step("lw_id", EnId);
    check_eq("lw_id_srcb", 32'(ctrl_if.alusrc_b), 32'd1);
    check_eq("lw_id_ext", 32'(ctrl_if.ext_op), 32'd1);
    step("lw_ex", EnEx);
    check_eq("lw_ex_aluop", 32'(ctrl_if.alu_op), 32'(ALU_ADD));
    check_eq("lw_ex_srcb", 32'(ctrl_if.alusrc_b), 32'd1);
    step("lw_mem", EnMemR);
    step("lw_wb", EnWb);
    check_eq("lw_wb_wdsel", 32'(ctrl_if.wd_sel), 32'd1);
    check_eq("lw_wb_rdsel", 32'(ctrl_if.rd_sel), 32'd0);
    step("lw_next", EnIf);

    // beq taken
    ctrl_if.instr = 32'h10220003;
    ctrl_if.zero  = 1'b1;
    step("beqt_id", EnId);
    step("beqt_ex", EnExPc);
    check_eq("beqt_pcsrc", 32'(ctrl_if.pc_src), 32'd1);
    check_eq("beqt_aluop", 32'(ctrl_if.alu_op), 32'(ALU_SUB));
    step("beqt_next", EnIf);

    // beq not taken
    ctrl_if.zero = 1'b0;
    step("beqn_id", EnId);
    step("beqn_ex", EnEx);
    step("beqn_next", EnIf);

    // add with overflow: trap, no write-back
    ctrl_if.instr    = 32'h00221820;
    ctrl_if.overflow = 1'b1;
    step("addov_id", EnId);
    step("addov_ex", EnExOv);
    step("addov_next", EnIf);

    // add without overflow completes normally
    ctrl_if.overflow = 1'b0;
    step("add_id", EnId);
    step("add_ex", EnEx);
    step("add_wb", EnWb);
    step("add_next", EnIf);

    // undecodable opcode
    ctrl_if.instr = 32'hFC000000;
    step("ill_id", EnIdIll);
    step("ill_next", EnIf);

    // j
    ctrl_if.instr = 32'h08000010;
    step("j_id", EnId);
    step("j_ex", EnExPc);
    check_eq("j_pcsrc", 32'(ctrl_if.pc_src), 32'd2);
    step("j_next", EnIf);

    // jal
    ctrl_if.instr = 32'h0C000010;
    step("jal_id", EnId);
    step("jal_ex", EnExPc);
    check_eq("jal_pcsrc", 32'(ctrl_if.pc_src), 32'd2);
    step("jal_wb", EnWb);
    check_eq("jal_rdsel", 32'(ctrl_if.rd_sel), 32'd2);
    check_eq("jal_wdsel", 32'(ctrl_if.wd_sel), 32'd2);
    step("jal_next", EnIf);

    // jr $31
    ctrl_if.instr = 32'h03E00008;
    step("jr_id", EnId);
    step("jr_ex", EnExPc);
    check_eq("jr_pcsrc", 32'(ctrl_if.pc_src), 32'd3);
    step("jr_next", EnIf);

    // andi: zero-extended immediate
    ctrl_if.instr = 32'h3022FFFF;
    step("andi_id", EnId);
    check_eq("andi_ext", 32'(ctrl_if.ext_op), 32'd0);
    check_eq("andi_srcb", 32'(ctrl_if.alusrc_b), 32'd1);
    step("andi_ex", EnEx);
    check_eq("andi_aluop", 32'(ctrl_if.alu_op), 32'(ALU_AND));
    step("andi_wb", EnWb);
    check_eq("andi_rdsel", 32'(ctrl_if.rd_sel), 32'd0);
    step("andi_next", EnIf);

    // bgez taken
    ctrl_if.instr = 32'h04210002;
    ctrl_if.gez   = 1'b1;
    step("bgez_id", EnId);
    step("bgez_ex", EnExPc);
    check_eq("bgez_pcsrc", 32'(ctrl_if.pc_src), 32'd1);
    step("bgez_next", EnIf);
    ctrl_if.gez = 1'b0;

    // sw interrupted by reset in MEM
    ctrl_if.instr = 32'hAC220004;
    step("sw_id", EnId);
    step("sw_ex", EnEx);
    step("sw_mem", EnMemW);
    rstn = 1'b0;
    #1;
    check_eq("swrst_memwr", 32'(ctrl_if.mem_write), 32'd0);
    check_eq("swrst_en", 32'(en), 32'(EnNone));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("swrst_held", 32'(en), 32'(EnNone));
    step("swrst_if", EnIf);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
